// File: rtl/aes_pkg.sv
// Shared AES definitions for the substitution scheduler slice.
//   sbox_sched_state_t : scheduler FSM encoding
//   AES_*_W            : state / word / byte widths
//   AES_SBOX           : forward S-box table, element x is S(x)
//   sbox_lookup        : table lookup helper used by each s_box lane
package aes_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sbox_sched_state_t;

   localparam int AES_STATE_W = 128;
   localparam int AES_WORD_W  = 32;
   localparam int AES_BYTE_W  = 8;

   // Ascending packed range: the first listed byte is element 0.
   localparam logic [0:255][7:0] AES_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
      return AES_SBOX[x];
   endfunction

endpackage

// File: rtl/sbox_bank.sv
// s_box     : one combinational AES forward S-box lane.
//   in_byte  in  8   byte to substitute
//   out_byte out 8   S(in_byte)
// sbox_bank : NUM_SBOX independent s_box lanes on flat buses.
//   lane_in  in  NUM_SBOX*8  lane i = lane_in[8i+7:8i]
//   lane_out out NUM_SBOX*8  lane i = S(lane i input)
module s_box
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = sbox_lookup(in_byte);

endmodule

module sbox_bank
   import aes_pkg::*;
#(
   parameter int NUM_SBOX = 4
)(
   input  logic [NUM_SBOX*AES_BYTE_W-1:0] lane_in,
   output logic [NUM_SBOX*AES_BYTE_W-1:0] lane_out
);

   for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
      s_box u_s_box (
         .in_byte  (lane_in [i*AES_BYTE_W +: AES_BYTE_W]),
         .out_byte (lane_out[i*AES_BYTE_W +: AES_BYTE_W])
      );
   end

endmodule

// File: rtl/sbox_scheduler.sv
// Shares one bank of NUM_SBOX S-box lanes between the round datapath
// (SubBytes over a 128-bit state in BEATS = 16/NUM_SBOX beats) and the key
// schedule (SubWord, one beat). Key requests win, except that after
// KEY_MAX_CONSEC consecutive key grants during a data job one data beat is
// forced through.
//   clk, rst        clock / asynchronous active-high reset
//   data_valid/ready/in            128-bit job handshake (ready only in IDLE)
//   data_out_valid/ready/data_out  result, held until data_out_ready
//   key_valid/ready/in             combinational SubWord grant
//   key_out_valid/key_out          pulse the cycle after a grant / held word
module sbox_scheduler
   import aes_pkg::*;
#(
   parameter int NUM_SBOX       = 4,
   parameter int KEY_MAX_CONSEC = 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   data_valid,
   output logic                   data_ready,
   input  logic [AES_STATE_W-1:0] data_in,
   output logic                   data_out_valid,
   input  logic                   data_out_ready,
   output logic [AES_STATE_W-1:0] data_out,
   input  logic                   key_valid,
   output logic                   key_ready,
   input  logic [AES_WORD_W-1:0]  key_in,
   output logic                   key_out_valid,
   output logic [AES_WORD_W-1:0]  key_out
);

   localparam int BEATS  = 16 / NUM_SBOX;
   localparam int LANE_W = NUM_SBOX * AES_BYTE_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int RUN_W  = $clog2(KEY_MAX_CONSEC + 1);

   sbox_sched_state_t      state_q, state_d;
   logic [BEAT_W-1:0]      beat_q;
   logic [RUN_W-1:0]       key_run_q;
   logic [AES_STATE_W-1:0] in_buf_q;
   logic [LANE_W-1:0]      bank_in, bank_out;
   logic                   data_beat;
   logic                   last_beat;
   logic                   key_blocked;

   // Starvation guard: once the key has taken KEY_MAX_CONSEC beats in a row
   // from a running job, the next beat belongs to the data.
   assign key_blocked = (state_q == RUN) && (key_run_q == RUN_W'(KEY_MAX_CONSEC));
   assign key_ready   = key_valid && !key_blocked;
   assign data_ready  = (state_q == IDLE);
   assign data_beat   = (state_q == RUN) && !key_ready;
   assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));

   // Idle lanes see zero so the bank does not toggle on stale buffer bytes.
   always_comb begin
      bank_in = '0;
      if (key_ready) begin
         bank_in[AES_WORD_W-1:0] = key_in;
      end else if (data_beat) begin
         bank_in = in_buf_q[int'(beat_q)*LANE_W +: LANE_W];
      end
   end

   sbox_bank #(.NUM_SBOX(NUM_SBOX)) u_sbox_bank (
      .lane_in  (bank_in),
      .lane_out (bank_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (data_valid)             state_d = RUN;
         RUN:     if (data_beat && last_beat) state_d = DONE;
         DONE:    if (data_out_ready)         state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   // Beat/stall bookkeeping and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q         <= '0;
         key_run_q      <= '0;
         in_buf_q       <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         key_out        <= '0;
         key_out_valid  <= 1'b0;
      end else begin
         key_out_valid <= key_ready;
         if (key_ready) begin
            key_out <= bank_out[AES_WORD_W-1:0];
         end

         if ((state_q == IDLE) && data_valid) begin
            in_buf_q <= data_in;
            beat_q   <= '0;
         end

         if (data_beat) begin
            data_out[int'(beat_q)*LANE_W +: LANE_W] <= bank_out;
            beat_q <= beat_q + 1'b1;
         end

         // Any data beat, and any cycle outside RUN, ends the key run.
         if ((state_q == RUN) && key_ready) begin
            key_run_q <= key_run_q + 1'b1;
         end else begin
            key_run_q <= '0;
         end

         if (data_beat && last_beat) begin
            data_out_valid <= 1'b1;
         end else if ((state_q == DONE) && data_out_ready) begin
            data_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sbox_scheduler.sv
module tb_sbox_scheduler;

   localparam int NUM_SBOX       = 4;
   localparam int KEY_MAX_CONSEC = 1;
   localparam int BEATS          = 16 / NUM_SBOX;

   logic         clk = 1'b0;
   logic         rst;
   logic         data_valid, data_ready;
   logic [127:0] data_in;
   logic         data_out_valid, data_out_ready;
   logic [127:0] data_out;
   logic         key_valid, key_ready;
   logic [31:0]  key_in;
   logic         key_out_valid;
   logic [31:0]  key_out;

   sbox_scheduler #(.NUM_SBOX(NUM_SBOX), .KEY_MAX_CONSEC(KEY_MAX_CONSEC)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_valid     (data_valid),
      .data_ready     (data_ready),
      .data_in        (data_in),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .data_out       (data_out),
      .key_valid      (key_valid),
      .key_ready      (key_ready),
      .key_in         (key_in),
      .key_out_valid  (key_out_valid),
      .key_out        (key_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference S-box derived from GF(2^8) inversion plus the affine map.
   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] sub_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[s[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[w[8*i +: 8]];
      return r;
   endfunction

   // Job-level model: is a job being processed, how many beats it has had,
   // how many key grants in a row it has suffered, is a result waiting.
   bit           m_busy, m_waiting, m_kvalid;
   int           m_beats, m_consec;
   logic [127:0] m_job, m_result;
   logic [31:0]  m_kout;

   task automatic model_reset();
      m_busy = 0; m_waiting = 0; m_kvalid = 0;
      m_beats = 0; m_consec = 0;
      m_job = '0; m_result = '0; m_kout = '0;
   endtask

   // One clock: inputs are set before the call, at a falling edge.
   task automatic step();
      bit exp_kr;
      #1;
      exp_kr = key_valid && !(m_busy && m_consec == KEY_MAX_CONSEC);
      check("key_ready", 128'(key_ready), 128'(exp_kr));
      check("data_ready", 128'(data_ready), 128'(!m_busy && !m_waiting));
      @(posedge clk);
      m_kvalid = exp_kr;
      if (exp_kr) m_kout = sub_word(key_in);
      if (m_busy) begin
         if (exp_kr) m_consec++;
         else begin
            m_consec = 0;
            m_beats++;
            if (m_beats == BEATS) begin
               m_busy = 0; m_waiting = 1; m_result = sub_state(m_job);
            end
         end
      end else if (m_waiting) begin
         if (data_out_ready) m_waiting = 0;
      end else if (data_valid) begin
         m_busy = 1; m_job = data_in; m_beats = 0; m_consec = 0;
      end
      @(negedge clk);
      check("key_out_valid", 128'(key_out_valid), 128'(m_kvalid));
      check("key_out", 128'(key_out), 128'(m_kout));
      check("data_out_valid", 128'(data_out_valid), 128'(m_waiting));
      if (!m_busy) check("data_out", data_out, m_result);
   endtask

   // Accepts a job this cycle, then counts cycles until data_out_valid.
   task automatic run_job(input logic [127:0] d, output int lat);
      data_valid = 1; data_in = d;
      step();
      data_valid = 0;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!data_out_valid && lat < 60);
   endtask

   task automatic apply_reset();
      data_valid = 0; key_valid = 0; data_out_ready = 0;
      rst = 1;
      #1;
      check("rst_data_out", data_out, 128'h0);
      check("rst_data_out_valid", 128'(data_out_valid), 128'h0);
      check("rst_key_out", 128'(key_out), 128'h0);
      check("rst_key_out_valid", 128'(key_out_valid), 128'h0);
      check("rst_data_ready", 128'(data_ready), 128'h1);
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      int lat;
      build_sbox();
      model_reset();
      rst = 1; data_valid = 0; data_in = '0; data_out_ready = 0;
      key_valid = 0; key_in = '0;
      @(negedge clk);
      apply_reset();

      // Key request while idle
      key_valid = 1; key_in = 32'hCF4F3C09;
      step();
      key_valid = 0;
      check("t1_key_out", 128'(key_out), 128'h8A84EB01);
      check("t1_key_pulse", 128'(key_out_valid), 128'h1);
      step();
      check("t1_pulse_end", 128'(key_out_valid), 128'h0);

      // Plain job, result held while consumer stalls
      run_job(128'h0F0E0D0C0B0A09080706050403020100, lat);
      check("t2_latency", 128'(lat), 128'(BEATS));
      check("t2_data_out", data_out, 128'h76ABD7FE2B670130C56F6BF27B777C63);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_hold", 128'(data_out_valid), 128'h1);
      end
      // New job offered and key requested while DONE
      data_valid = 1; data_in = '1; key_valid = 1; key_in = 32'h00000000;
      step();
      check("t5_no_accept", 128'(data_out_valid), 128'h1);
      check("t5_key_out", 128'(key_out), 128'h63636363);
      data_valid = 0; key_valid = 0; data_out_ready = 1;
      step();
      check("t2_drop", 128'(data_out_valid), 128'h0);
      check("t2_kept", data_out, 128'h76ABD7FE2B670130C56F6BF27B777C63);

      // Job under continuous key pressure
      key_valid = 1; key_in = 32'h00000053;
      run_job(128'h0F0E0D0C0B0A09080706050403020100, lat);
      check("t3_latency", 128'(lat), 128'(BEATS * (KEY_MAX_CONSEC + 1)));
      check("t3_key_out", 128'(key_out), 128'h636363ED);
      check("t3_data_out", data_out, 128'h76ABD7FE2B670130C56F6BF27B777C63);
      key_valid = 0;
      step();

      // Extreme patterns
      run_job({128{1'b1}}, lat);
      check("t4_ones", data_out, {16{8'h16}});
      step();
      run_job(128'h0, lat);
      check("t4_zeros", data_out, {16{8'h63}});
      check("t4_latency", 128'(lat), 128'(BEATS));
      step();

      // Reset in the middle of a job, then a fresh job
      data_valid = 1; data_in = 128'h00112233445566778899AABBCCDDEEFF;
      step();
      data_valid = 0;
      step();
      step();
      apply_reset();
      run_job(128'h3243F6A8885A308D313198A2E0370734, lat);
      check("t6_latency", 128'(lat), 128'(BEATS));
      check("t6_data_out", data_out, sub_state(128'h3243F6A8885A308D313198A2E0370734));
      step();

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         data_valid     = ($urandom_range(0, 3) == 0);
         data_in        = {$urandom, $urandom, $urandom, $urandom};
         key_valid      = ($urandom_range(0, 1) == 1);
         key_in         = $urandom;
         data_out_ready = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
